// File: rtl/spi_bank_rx_if.sv
// Bank-load link bundle: serial side (sos/eos/data_in) and SRAM write side of spi_bank_rx.
interface spi_bank_rx_if #(
    parameter int MEM_BW    = 16,
    parameter int MEM_DEPTH = 256
);
    localparam int AW = $clog2(MEM_DEPTH);

    logic              sos;
    logic              eos;
    logic              data_in;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [MEM_BW-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              short_err;
    logic              chk_err;

    modport slave (
        input  sos, eos, data_in,
        output wr_en, wr_addr, wr_data, busy, done, short_err, chk_err
    );

    modport master (
        output sos, eos, data_in,
        input  wr_en, wr_addr, wr_data, busy, done, short_err, chk_err
    );
endinterface

// File: rtl/spi_bank_rx.sv
// Serial-to-parallel bank-load receiver: MSB-first words written to consecutive SRAM addresses.
// Optional trailing XOR checksum word enabled by defining SPI_RX_CHECKSUM_EN.
module spi_bank_rx #(
    parameter int MEM_BW          = 16,
    parameter int MEM_DEPTH       = 256,
    parameter int NUM_VALID_LINES = 35
) (
    input  logic            clk,
    input  logic            reset,
    spi_bank_rx_if.slave    bus
);
    localparam int AW   = $clog2(MEM_DEPTH);
    localparam int BW_W = $clog2(MEM_BW);
    localparam int LW   = $clog2(NUM_VALID_LINES + 2);
`ifdef SPI_RX_CHECKSUM_EN
    localparam int FINAL_LINE = NUM_VALID_LINES;
`else
    localparam int FINAL_LINE = NUM_VALID_LINES - 1;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [MEM_BW-1:0] shift_q, shift_d;
    logic [BW_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [LW-1:0]     line_cnt_q, line_cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [AW-1:0]     wr_addr_q, wr_addr_d;
    logic [MEM_BW-1:0] wr_data_q, wr_data_d;
    logic              done_q, done_d;
    logic              short_q, short_d;
    logic [MEM_BW-1:0] word;
    logic              word_end;
    logic              last_bit;
`ifdef SPI_RX_CHECKSUM_EN
    logic [MEM_BW-1:0] xor_q, xor_d;
    logic              chk_q, chk_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            line_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            short_q    <= 1'b0;
`ifdef SPI_RX_CHECKSUM_EN
            xor_q      <= '0;
            chk_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            line_cnt_q <= line_cnt_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            short_q    <= short_d;
`ifdef SPI_RX_CHECKSUM_EN
            xor_q      <= xor_d;
            chk_q      <= chk_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        line_cnt_d = line_cnt_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = done_q;
        short_d    = short_q;
`ifdef SPI_RX_CHECKSUM_EN
        xor_d      = xor_q;
        chk_d      = chk_q;
`endif
        word     = {shift_q[MEM_BW-2:0], bus.data_in};
        word_end = (bit_cnt_q == BW_W'(MEM_BW - 1));
        last_bit = word_end && (line_cnt_q == LW'(FINAL_LINE));

        case (state_q)
            S_IDLE: begin
                done_d     = 1'b0;
                short_d    = 1'b0;
                bit_cnt_d  = '0;
                line_cnt_d = '0;
`ifdef SPI_RX_CHECKSUM_EN
                chk_d      = 1'b0;
                xor_d      = '0;
`endif
                if (bus.sos) state_d = S_RECV;
            end
            S_RECV: begin
                if (bus.sos) begin
                    // Restart: drop the partial word, addresses begin again at 0.
                    bit_cnt_d  = '0;
                    line_cnt_d = '0;
`ifdef SPI_RX_CHECKSUM_EN
                    xor_d      = '0;
`endif
                end else if (bus.eos && !last_bit) begin
                    state_d = S_DONE;
                    short_d = 1'b1;
                end else begin
                    shift_d   = word;
                    bit_cnt_d = bit_cnt_q + BW_W'(1);
                    if (word_end) begin
                        bit_cnt_d  = '0;
                        line_cnt_d = line_cnt_q + LW'(1);
                        if (line_cnt_q < LW'(NUM_VALID_LINES)) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = AW'(line_cnt_q);
                            wr_data_d = word;
`ifdef SPI_RX_CHECKSUM_EN
                            xor_d     = xor_q ^ word;
`endif
                        end
                        if (line_cnt_q == LW'(FINAL_LINE)) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
`ifdef SPI_RX_CHECKSUM_EN
                            chk_d   = (word != xor_q);
`endif
                        end
                    end
                end
            end
            S_DONE: begin
                if (bus.sos) begin
                    state_d    = S_RECV;
                    done_d     = 1'b0;
                    short_d    = 1'b0;
                    bit_cnt_d  = '0;
                    line_cnt_d = '0;
`ifdef SPI_RX_CHECKSUM_EN
                    chk_d      = 1'b0;
                    xor_d      = '0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.busy      = (state_q == S_RECV);
    assign bus.done      = done_q;
    assign bus.short_err = short_q;
`ifdef SPI_RX_CHECKSUM_EN
    assign bus.chk_err   = chk_q;
`else
    assign bus.chk_err   = 1'b0;
`endif

endmodule

// File: tb/tb_spi_bank_rx.sv
// Directed-plus-random bench for spi_bank_rx; expected writes and flags come from a stream-level model.
module tb_spi_bank_rx;
    localparam int BW  = 16;
    localparam int NUM = 35;
`ifdef SPI_RX_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    typedef struct {
        int          cyc;
        int          addr;
        logic [15:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   passes = 0;
    logic [15:0] words[$];
    wr_t  exp_q[$];

    spi_bank_rx_if #(.MEM_BW(BW), .MEM_DEPTH(256)) bus ();

    spi_bank_rx #(.MEM_BW(BW), .MEM_DEPTH(256), .NUM_VALID_LINES(NUM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic add_checksum();
`ifdef SPI_RX_CHECKSUM_EN
        logic [15:0] x = '0;
        for (int k = 0; k < NUM; k++) x ^= words[k];
        words.push_back(x);
`endif
    endtask

    // Word k's write is visible after edge S+(k+1)*16; the stream ends after edge S+16*words or at eos+1.
    task automatic run_stream(input string tag, input int stop_bit, input int eos_bit);
        int   nfull   = (NUM + CS) * BW;
        bit   normal  = (eos_bit < 0) || (eos_bit == nfull - 1);
        int   end_cyc = normal ? nfull : eos_bit + 1;
        int   n_cyc   = (stop_bit < end_cyc) ? stop_bit : end_cyc;
        logic exp_chk = 1'b0;
        logic [15:0] x = '0;
        bit   exp_wr;
        exp_q.delete();
        for (int k = 0; k < NUM; k++) begin
            int wc = (k + 1) * BW;
            if (wc <= end_cyc && (normal || wc < end_cyc))
                exp_q.push_back('{cyc: wc, addr: k, data: words[k]});
        end
        if (CS != 0 && normal) begin
            for (int k = 0; k < NUM; k++) x ^= words[k];
            exp_chk = (words[NUM] != x);
        end

        bus.sos = 1'b1;
        tick();
        bus.sos = 1'b0;
        check({tag, " busy after sos"}, bus.busy, 1'b1);
        check({tag, " done cleared"}, bus.done, 1'b0);
        check({tag, " short cleared"}, bus.short_err, 1'b0);
        for (int i = 0; i < n_cyc; i++) begin
            bus.data_in = words[i / BW][BW - 1 - (i % BW)];
            bus.eos     = (i == eos_bit);
            tick();
            exp_wr = (exp_q.size() > 0) && (exp_q[0].cyc == i + 1);
            check($sformatf("%s wr_en c%0d", tag, i + 1), bus.wr_en, exp_wr);
            if (exp_wr) begin
                check($sformatf("%s wr_addr c%0d", tag, i + 1), bus.wr_addr, exp_q[0].addr);
                check($sformatf("%s wr_data c%0d", tag, i + 1), bus.wr_data, exp_q[0].data);
                void'(exp_q.pop_front());
            end
            if (i + 1 < end_cyc)
                check($sformatf("%s busy c%0d", tag, i + 1), bus.busy, 1'b1);
        end
        bus.data_in = 1'b0;
        bus.eos     = 1'b0;
        if (n_cyc == end_cyc) begin
            check({tag, " pending writes"}, exp_q.size(), 0);
            check({tag, " done"}, bus.done, normal);
            check({tag, " short_err"}, bus.short_err, !normal);
            check({tag, " chk_err"}, bus.chk_err, exp_chk);
            check({tag, " busy end"}, bus.busy, 1'b0);
            for (int i = 0; i < 4; i++) begin
                bus.data_in = 1'($urandom);
                bus.eos     = 1'($urandom);
                tick();
                check({tag, " hold wr_en"}, bus.wr_en, 1'b0);
                check({tag, " hold done"}, bus.done, normal);
                check({tag, " hold short"}, bus.short_err, !normal);
            end
            bus.data_in = 1'b0;
            bus.eos     = 1'b0;
        end
    endtask

    task automatic fill_random();
        words.delete();
        for (int k = 0; k < NUM; k++) words.push_back(16'($urandom));
        add_checksum();
    endtask

    initial begin
        int e;
        int nfull = (NUM + CS) * BW;
        reset       = 1'b1;
        bus.sos     = 1'b0;
        bus.eos     = 1'b0;
        bus.data_in = 1'b0;
        #12;
        check("reset wr_en", bus.wr_en, 1'b0);
        check("reset wr_addr", bus.wr_addr, 0);
        check("reset wr_data", bus.wr_data, 0);
        check("reset busy", bus.busy, 1'b0);
        check("reset done", bus.done, 1'b0);
        check("reset short_err", bus.short_err, 1'b0);
        check("reset chk_err", bus.chk_err, 1'b0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 20; i++) begin
            bus.data_in = 1'($urandom);
            bus.eos     = 1'($urandom);
            tick();
            check("idle wr_en", bus.wr_en, 1'b0);
            check("idle busy", bus.busy, 1'b0);
        end
        bus.eos = 1'b0;

        words.delete();
        for (int k = 0; k < NUM; k++) words.push_back(16'hA500 + 16'(k));
        add_checksum();
        run_stream("nominal", nfull, -1);

        fill_random();
        run_stream("early_eos", nfull, 100);

        fill_random();
        run_stream("eos_last", nfull, nfull - 1);

        for (int r = 0; r < 3; r++) begin
            fill_random();
            e = $urandom_range(0, nfull - 2);
            if (e % BW == BW - 1) e = e - 1;
            run_stream($sformatf("rand_eos%0d", e), nfull, e);
        end

        fill_random();
        run_stream("restart_a", 40, -1);
        words.delete();
        for (int k = 0; k < NUM; k++) words.push_back(16'h1234);
        add_checksum();
        run_stream("restart_b", nfull, -1);

        fill_random();
        run_stream("rst_mid", 160, -1);
        #2;
        reset = 1'b1;
        #1;
        check("async wr_en", bus.wr_en, 1'b0);
        check("async wr_addr", bus.wr_addr, 0);
        check("async wr_data", bus.wr_data, 0);
        check("async busy", bus.busy, 1'b0);
        check("async done", bus.done, 1'b0);
        check("async short", bus.short_err, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bus.data_in = 1'($urandom);
            tick();
            check("post_rst wr_en", bus.wr_en, 1'b0);
            check("post_rst busy", bus.busy, 1'b0);
        end
        bus.data_in = 1'b0;

`ifdef SPI_RX_CHECKSUM_EN
        words.delete();
        for (int k = 0; k < NUM; k++) words.push_back(16'(k + 1));
        add_checksum();
        run_stream("cksum_ok", nfull, -1);
        words[NUM] = words[NUM] ^ 16'h0040;
        run_stream("cksum_bad", nfull, -1);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
